// File: rtl/gb_alu16_seq_if.sv
// gb_alu16_seq_if
//   Bundles the request/response handshake of the 16-bit sequencer with the
//   8-bit ALU operand/flag bus it drives.
//   Request side : start, op, opa, opb, f_in   -> sequencer
//   Response side: busy, done, result, f_out   <- sequencer
//   ALU drive    : alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16
//   ALU return   : alu_q, alu_f_out (combinational from the ALU)
//   master = requester + ALU side, slave = the sequencer itself.
interface gb_alu16_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [7:0]  f_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [7:0]  f_out;
    logic [3:0]  alu_op;
    logic [7:0]  alu_busa;
    logic [7:0]  alu_busb;
    logic [7:0]  alu_f_in;
    logic        alu_arith16;
    logic        alu_z16;
    logic [7:0]  alu_q;
    logic [7:0]  alu_f_out;

    modport master (
        output start, op, opa, opb, f_in, alu_q, alu_f_out,
        input  busy, done, result, f_out,
        input  alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16
    );

    modport slave (
        input  start, op, opa, opb, f_in, alu_q, alu_f_out,
        output busy, done, result, f_out,
        output alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16
    );
endinterface

// File: rtl/gb_alu16_seq.sv
// gb_alu16_seq
//   Runs the Game Boy 16-bit operations (ADD HL,rr / ADD SP,e8 / INC rr /
//   DEC rr) as two chained passes through the 8-bit ALU: low byte, then high
//   byte with the low-pass carry fed back in through F_In.
//   Ports:
//     clk   - system clock
//     reset - synchronous, active-high
//     bus   - gb_alu16_seq_if.slave: start/op/opa/opb/f_in request,
//             busy/done/result/f_out response, alu_* drive and alu_q/alu_f_out
//             return from the combinational ALU.
module gb_alu16_seq #(
    parameter int FLAG_Z = 7,
    parameter int FLAG_N = 6,
    parameter int FLAG_H = 5,
    parameter int FLAG_C = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    gb_alu16_seq_if.slave        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_ADC = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_SBC = 4'b0011;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [7:0]  f_in_q, f_in_d;
    logic [7:0]  lo_q, lo_d;
    logic        c_lo_q, c_lo_d;
    logic        h_lo_q, h_lo_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  f_out_q, f_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        accept_s;

    logic [3:0]  alu_op_s;
    logic [7:0]  alu_busa_s;
    logic [7:0]  alu_busb_s;
    logic [7:0]  alu_f_in_s;
    logic        alu_arith16_s;

    // Final F: ADD HL keeps Z and reports the bit-11/bit-15 carries; ADD SP,e8
    // clears Z/N and reports the low-byte bit-3/bit-7 carries; INC/DEC leave
    // flags untouched. The low nibble of F is always zero.
    function automatic logic [7:0] final_flags(
        input logic [1:0] op,
        input logic [7:0] f_in,
        input logic       h_lo,
        input logic       c_lo,
        input logic       h_hi,
        input logic       c_hi
    );
        logic [7:0] f;
        f = 8'h00;
        case (op)
            2'b00: begin
                f[FLAG_Z] = f_in[FLAG_Z];
                f[FLAG_H] = h_hi;
                f[FLAG_C] = c_hi;
            end
            2'b01: begin
                f[FLAG_H] = h_lo;
                f[FLAG_C] = c_lo;
            end
            default: begin
                f[FLAG_Z] = f_in[FLAG_Z];
                f[FLAG_N] = f_in[FLAG_N];
                f[FLAG_H] = f_in[FLAG_H];
                f[FLAG_C] = f_in[FLAG_C];
            end
        endcase
        return f;
    endfunction

    assign accept_s = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Sequencing: latch the request on accept, capture each ALU pass.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        f_in_d   = f_in_q;
        lo_d     = lo_q;
        c_lo_d   = c_lo_q;
        h_lo_d   = h_lo_q;
        result_d = result_q;
        f_out_d  = f_out_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    state_d = S_LO;
                    op_d    = bus.op;
                    opa_d   = bus.opa;
                    opb_d   = bus.opb;
                    f_in_d  = bus.f_in;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LO: begin
                lo_d    = bus.alu_q;
                c_lo_d  = bus.alu_f_out[FLAG_C];
                h_lo_d  = bus.alu_f_out[FLAG_H];
                state_d = S_HI;
            end
            S_HI: begin
                result_d = {bus.alu_q, lo_q};
                f_out_d  = final_flags(op_q, f_in_q, h_lo_q, c_lo_q,
                                       bus.alu_f_out[FLAG_H], bus.alu_f_out[FLAG_C]);
                state_d  = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_LO) || (state_d == S_HI);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 2'b00;
            opa_q    <= 16'h0000;
            opb_q    <= 16'h0000;
            f_in_q   <= 8'h00;
            lo_q     <= 8'h00;
            c_lo_q   <= 1'b0;
            h_lo_q   <= 1'b0;
            result_q <= 16'h0000;
            f_out_q  <= 8'h00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            f_in_q   <= f_in_d;
            lo_q     <= lo_d;
            c_lo_q   <= c_lo_d;
            h_lo_q   <= h_lo_d;
            result_q <= result_d;
            f_out_q  <= f_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // ALU drive decode. The low pass forces C=0 in F_In so ADD/SUB start
    // clean; the high pass feeds the low-pass carry/borrow into ADC/SBC.
    always_comb begin
        alu_op_s      = 4'b0000;
        alu_busa_s    = 8'h00;
        alu_busb_s    = 8'h00;
        alu_f_in_s    = 8'h00;
        alu_arith16_s = 1'b0;
        case (state_q)
            S_LO: begin
                alu_busa_s         = opa_q[7:0];
                alu_f_in_s         = f_in_q;
                alu_f_in_s[FLAG_C] = 1'b0;
                case (op_q)
                    2'b00, 2'b01: begin
                        alu_op_s   = ALU_ADD;
                        alu_busb_s = opb_q[7:0];
                    end
                    2'b10: begin
                        alu_op_s   = ALU_ADD;
                        alu_busb_s = 8'h01;
                    end
                    default: begin
                        alu_op_s   = ALU_SUB;
                        alu_busb_s = 8'h01;
                    end
                endcase
            end
            S_HI: begin
                alu_busa_s         = opa_q[15:8];
                alu_f_in_s         = f_in_q;
                alu_f_in_s[FLAG_C] = c_lo_q;
                alu_arith16_s      = 1'b1;
                case (op_q)
                    2'b00: begin
                        alu_op_s   = ALU_ADC;
                        alu_busb_s = opb_q[15:8];
                    end
                    2'b01: begin
                        // e8 is signed: the high byte adds its sign extension
                        alu_op_s   = ALU_ADC;
                        alu_busb_s = {8{opb_q[7]}};
                    end
                    2'b10: begin
                        alu_op_s   = ALU_ADC;
                        alu_busb_s = 8'h00;
                    end
                    default: begin
                        alu_op_s   = ALU_SBC;
                        alu_busb_s = 8'h00;
                    end
                endcase
            end
            default: begin
                alu_op_s      = 4'b0000;
                alu_busa_s    = 8'h00;
                alu_busb_s    = 8'h00;
                alu_f_in_s    = 8'h00;
                alu_arith16_s = 1'b0;
            end
        endcase
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.f_out       = f_out_q;
    assign bus.alu_op      = alu_op_s;
    assign bus.alu_busa    = alu_busa_s;
    assign bus.alu_busb    = alu_busb_s;
    assign bus.alu_f_in    = alu_f_in_s;
    assign bus.alu_arith16 = alu_arith16_s;
    assign bus.alu_z16     = 1'b0;

endmodule

// File: tb/tb_gb_alu16_seq.sv
// tb_gb_alu16_seq
//   Directed bench for gb_alu16_seq. A small 8-bit ALU model answers the
//   DUT's ALU bus; a 16-bit reference model predicts busy/done/result/f_out
//   each cycle from plain 16-bit arithmetic; directed vectors also carry
//   hand-computed literals.
module tb_gb_alu16_seq;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic cmp_en;

    gb_alu16_seq_if bus ();

    gb_alu16_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // 8-bit ALU stand-in: ADD/ADC/SUB/SBC with Z,N,H,C in bits 7..4.
    always_comb begin
        int a, b, ci, r, hs;
        logic cf, hf, nf;
        a  = int'(bus.alu_busa);
        b  = int'(bus.alu_busb);
        ci = int'(bus.alu_f_in[4]);
        r  = 0;
        cf = 1'b0;
        hf = 1'b0;
        nf = 1'b0;
        hs = 0;
        case (bus.alu_op)
            4'b0000: begin r = a + b;      hs = (a % 16) + (b % 16);      cf = r > 255; hf = hs > 15; end
            4'b0001: begin r = a + b + ci; hs = (a % 16) + (b % 16) + ci; cf = r > 255; hf = hs > 15; end
            4'b0010: begin r = a - b;      nf = 1'b1; cf = a < b;      hf = (a % 16) < (b % 16); end
            4'b0011: begin r = a - b - ci; nf = 1'b1; cf = a < b + ci; hf = (a % 16) < (b % 16) + ci; end
            default: begin r = 0; end
        endcase
        bus.alu_q     = 8'(r);
        bus.alu_f_out = {(8'(r) == 8'h00), nf, hf, cf, 4'h0};
    end

    // Reference: 16-bit result and flags straight from the instruction rules.
    function automatic logic [23:0] ref_op(input logic [1:0] op, input logic [15:0] a,
                                           input logic [15:0] b, input logic [7:0] fi);
        int ai, bi, e, s;
        logic h, c;
        logic [15:0] r;
        logic [7:0]  f;
        ai = int'(a);
        bi = int'(b);
        case (op)
            2'b00: begin
                s = ai + bi;
                r = 16'(s);
                h = ((ai % 4096) + (bi % 4096)) > 4095;
                c = s > 65535;
                f = {fi[7], 1'b0, h, c, 4'h0};
            end
            2'b01: begin
                e = (bi % 256 >= 128) ? (bi % 256) - 256 : (bi % 256);
                r = 16'(ai + e);
                h = ((ai % 16) + (bi % 16)) > 15;
                c = ((ai % 256) + (bi % 256)) > 255;
                f = {2'b00, h, c, 4'h0};
            end
            2'b10: begin
                r = 16'(ai + 1);
                f = {fi[7:4], 4'h0};
            end
            default: begin
                r = 16'(ai - 1);
                f = {fi[7:4], 4'h0};
            end
        endcase
        return {r, f};
    endfunction

    // Reference timing: 0 idle, 1 low pass, 2 high pass, 3 done.
    int          m_phase;
    logic [15:0] m_res, m_pend_res;
    logic [7:0]  m_f, m_pend_f;

    always @(posedge clk) begin
        if (reset) begin
            m_phase <= 0;
            m_res   <= 16'h0000;
            m_f     <= 8'h00;
        end else begin
            case (m_phase)
                0, 3: begin
                    if (bus.start) begin
                        {m_pend_res, m_pend_f} <= ref_op(bus.op, bus.opa, bus.opb, bus.f_in);
                        m_phase <= 1;
                    end else begin
                        m_phase <= 0;
                    end
                end
                1: m_phase <= 2;
                default: begin
                    m_phase <= 3;
                    m_res   <= m_pend_res;
                    m_f     <= m_pend_f;
                end
            endcase
        end
    end

    // Per-cycle compare against the reference.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",   {31'd0, bus.busy},  {31'd0, (m_phase == 1 || m_phase == 2)});
            chk("done",   {31'd0, bus.done},  {31'd0, (m_phase == 3)});
            chk("result", {16'd0, bus.result}, {16'd0, m_res});
            chk("f_out",  {24'd0, bus.f_out},  {24'd0, m_f});
            chk("z16",    {31'd0, bus.alu_z16}, 32'd0);
            if (m_phase == 0 || m_phase == 3) begin
                chk("alu_idle", {3'd0, bus.alu_op, bus.alu_busa, bus.alu_busb, bus.alu_f_in, bus.alu_arith16}, 32'd0);
            end else begin
                chk("arith16", {31'd0, bus.alu_arith16}, {31'd0, (m_phase == 2)});
            end
        end
    end

    task automatic drive(input logic s, input logic [1:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [7:0] fi);
        bus.start = s;
        bus.op    = o;
        bus.opa   = a;
        bus.opb   = b;
        bus.f_in  = fi;
    endtask

    task automatic run_op(input string nm, input logic [1:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [7:0] fi,
                          input logic [15:0] er, input logic [7:0] ef);
        int n;
        @(negedge clk);
        drive(1'b1, o, a, b, fi);
        @(negedge clk);
        bus.start = 1'b0;
        n = 1;
        while (!bus.done && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_lat"}, n, 32'd3);
        chk({nm, "_res"}, {16'd0, bus.result}, {16'd0, er});
        chk({nm, "_f"},   {24'd0, bus.f_out},  {24'd0, ef});
    endtask

    initial begin
        int ndone;
        checks = 0;
        errors = 0;
        cmp_en = 1'b0;
        reset  = 1'b1;
        drive(1'b0, 2'b00, 16'h0000, 16'h0000, 8'h00);
        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_res", {16'd0, bus.result}, 32'd0);
        chk("rst_busy", {30'd0, bus.busy, bus.done}, 32'd0);
        reset = 1'b0;

        // Pin the reference model to hand-computed values.
        chk("pin_add_hl", {8'd0, ref_op(2'b00, 16'h0FFF, 16'h0001, 8'h80)}, {8'd0, 16'h1000, 8'hA0});
        chk("pin_add_sp", {8'd0, ref_op(2'b01, 16'h0000, 16'h00FF, 8'hF0)}, {8'd0, 16'hFFFF, 8'h00});
        chk("pin_dec",    {8'd0, ref_op(2'b11, 16'h0000, 16'h0000, 8'hF0)}, {8'd0, 16'hFFFF, 8'hF0});

        run_op("add_hl_h11", 2'b00, 16'h0FFF, 16'h0001, 8'h80, 16'h1000, 8'hA0);
        run_op("add_hl_wrap", 2'b00, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 8'h30);
        run_op("add_hl_c15", 2'b00, 16'h8000, 16'h8000, 8'hF0, 16'h0000, 8'h90);
        run_op("add_hl_plain", 2'b00, 16'h1234, 16'h4321, 8'h00, 16'h5555, 8'h00);
        run_op("add_sp_pos", 2'b01, 16'hFFF8, 16'h0008, 8'hF0, 16'h0000, 8'h30);
        run_op("add_sp_m1", 2'b01, 16'h0000, 16'h00FF, 8'hF0, 16'hFFFF, 8'h00);
        run_op("add_sp_m128", 2'b01, 16'h0005, 16'h0080, 8'h00, 16'hFF85, 8'h00);
        run_op("add_sp_h", 2'b01, 16'h000F, 16'h0001, 8'hF0, 16'h0010, 8'h20);
        run_op("dec_wrap", 2'b11, 16'h0000, 16'h0000, 8'hF0, 16'hFFFF, 8'hF0);
        run_op("inc_wrap", 2'b10, 16'hFFFF, 16'h0000, 8'hF0, 16'h0000, 8'hF0);
        run_op("dec_mid", 2'b11, 16'h1000, 16'h0000, 8'h5A, 16'h0FFF, 8'h50);

        // start held high: one op every 3 cycles.
        @(negedge clk);
        drive(1'b1, 2'b10, 16'h00FF, 16'h0000, 8'h00);
        ndone = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        bus.start = 1'b0;
        chk("b2b_done_cnt", ndone, 32'd3);
        chk("b2b_res", {16'd0, bus.result}, 32'h0000_0100);
        @(negedge clk);

        // A start pulse during LO is ignored; the original operands complete.
        drive(1'b1, 2'b00, 16'h0100, 16'h0200, 8'h00);
        @(negedge clk);
        drive(1'b1, 2'b11, 16'hAAAA, 16'h5555, 8'hF0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("ign_done", {31'd0, bus.done}, 32'd1);
        chk("ign_res", {16'd0, bus.result}, 32'h0000_0300);
        @(negedge clk);
        chk("ign_no_extra", {31'd0, bus.done}, 32'd0);

        // Reset during HI aborts the op.
        drive(1'b1, 2'b00, 16'h1111, 16'h2222, 8'h00);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_out", {bus.busy, bus.done, 14'd0, bus.result}, 32'd0);
        chk("abort_alu", {3'd0, bus.alu_op, bus.alu_busa, bus.alu_busb, bus.alu_f_in, bus.alu_arith16}, 32'd0);
        run_op("after_abort", 2'b00, 16'h1111, 16'h2222, 8'h80, 16'h3333, 8'h80);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
